// File: rtl/gpr_file_mp_pkg.sv
// gpr_file_mp_pkg: shared definitions for the multi-port register file.
//   - Reset-active level (reset is synchronous, active-low).
//   - Default data/address bus widths.
//   - FSM state encoding for the zero-initialisation engine.
//   - Address-range helper shared by the top and the scoreboard.
// Optional feature macro: GPR_SCOREBOARD_EN. Define it on the tool command
// line (e.g. +define+GPR_SCOREBOARD_EN) to build the pending-write
// scoreboard. It is left undefined here, so the default build has no
// scoreboard and rd_pending is tied low.
package gpr_file_mp_pkg;

    // Level of rst that holds the block in reset.
    localparam logic GPR_RST_ACTIVE = 1'b0;

    // Default widths (register data bus and register address bus).
    localparam int GPR_BUS_W      = 32;
    localparam int GPR_ADDR_BUS_W = 5;

    // Init engine states.
    typedef enum logic {
        GPR_ST_INIT = 1'b0,
        GPR_ST_RUN  = 1'b1
    } gpr_state_e;

    // True for an address that names a real, writable register: not the
    // hardwired zero entry and inside the implemented depth.
    function automatic logic gpr_addr_ok(input int unsigned addr, input int unsigned depth);
        return (addr != 32'd0) && (addr < depth);
    endfunction

endpackage

// File: rtl/gpr_file_mp_scoreboard.sv
// gpr_scoreboard: DEPTH-bit pending-write vector for RAW hazard detection.
// Ports:
//   clk, rst          clock and synchronous active-low reset (clears all bits)
//   run               1 when the register file is in RUN; updates only then
//   sb_set_en/_addr   decode marks a destination register pending
//   wr_en/wr_addr     writeback ports; each enabled write clears its bit
//   rd_addr           read-port addresses to look up
//   rd_pend           raw pending bit per read port (0 for r0 / out of range)
// A set and a clear on the same entry in the same cycle leaves the bit set,
// because the set belongs to a newer producer than the completing write.
module gpr_scoreboard
    import gpr_file_mp_pkg::*;
#(
    parameter int ADDR_W = GPR_ADDR_BUS_W,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD-1:0]          rd_pend
);

    logic [DEPTH-1:0] pend_r;
    logic [DEPTH-1:0] pend_nxt_s;
    logic [DEPTH-1:0] clr_s;
    logic [DEPTH-1:0] set_s;

    // Per-entry clear/set masks; entry 0 can never be set.
    always_comb begin
        clr_s = '0;
        set_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < NUM_WR; i++) begin
                clr_s[k] = clr_s[k] |
                           (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(k)));
            end
            set_s[k] = sb_set_en && (sb_set_addr == ADDR_W'(k)) && (k != 0);
        end
        pend_nxt_s = run ? ((pend_r & ~clr_s) | set_s) : pend_r;
    end

    // Pending vector register.
    always_ff @(posedge clk) begin
        if (rst == GPR_RST_ACTIVE) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Lookup per read port; invalid addresses never report pending.
    always_comb begin
        rd_pend = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            rd_pend[j] = gpr_addr_ok(32'(rd_addr[j*ADDR_W +: ADDR_W]), DEPTH)
                       ? pend_r[rd_addr[j*ADDR_W +: ADDR_W]] : 1'b0;
        end
    end

endmodule

// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised multi-port general-purpose register file.
// After reset an init engine clears one entry per cycle (DEPTH cycles) and
// then the file enters RUN. Entry 0 always reads zero.
// Ports:
//   clk, rst      clock; synchronous active-low reset (restarts INIT)
//   wr_en         per-port write enable (NUM_WR)
//   wr_addr/data  packed write ports, port i at [i*W +: W]
//   rd_addr       packed read addresses (NUM_RD)
//   rd_data       combinational read data with same-cycle write bypass
//   rd_pending    1 = addressed register has an outstanding producer
//   sb_set_en/_addr  decode marks a destination register pending
//   init_busy     1 while the init engine is clearing the array
// Optional feature macro: GPR_SCOREBOARD_EN (scoreboard + rd_pending).
// Without it rd_pending is all-zeros and sb_set_* are unused.
module gpr_file_mp
    import gpr_file_mp_pkg::*;
#(
    parameter int DATA_W = GPR_BUS_W,
    parameter int ADDR_W = GPR_ADDR_BUS_W,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic                       sb_set_en,
    input  logic [ADDR_W-1:0]          sb_set_addr,
    output logic                       init_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    gpr_state_e         state_r;
    gpr_state_e         state_nxt_s;
    logic [ADDR_W-1:0]  init_cnt_r;
    logic [ADDR_W-1:0]  init_cnt_nxt_s;
    logic [DATA_W-1:0]  mem_r [DEPTH];
    logic               run_s;
    logic [NUM_RD-1:0]  rd_hit_s;

    assign run_s     = (state_r == GPR_ST_RUN);
    assign init_busy = (state_r == GPR_ST_INIT);

    // Init engine state and counter register.
    always_ff @(posedge clk) begin
        if (rst == GPR_RST_ACTIVE) begin
            state_r    <= GPR_ST_INIT;
            init_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
        end
    end

    // Init engine next state: walk 0..DEPTH-1, then stay in RUN.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            GPR_ST_INIT: begin
                if (init_cnt_r == LAST_IDX) begin
                    state_nxt_s    = GPR_ST_RUN;
                    init_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = GPR_ST_INIT;
                    init_cnt_nxt_s = init_cnt_r + ADDR_W'(1);
                end
            end
            GPR_ST_RUN: begin
                state_nxt_s    = GPR_ST_RUN;
                init_cnt_nxt_s = '0;
            end
            default: begin
                state_nxt_s    = GPR_ST_INIT;
                init_cnt_nxt_s = '0;
            end
        endcase
    end

    // Array update: clearing during INIT, port writes during RUN. Ports are
    // visited in ascending order so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (rst != GPR_RST_ACTIVE) begin
            if (!run_s) begin
                mem_r[init_cnt_r] <= '0;
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en[i] && gpr_addr_ok(32'(wr_addr[i*ADDR_W +: ADDR_W]), DEPTH)) begin
                        mem_r[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Combinational reads: zero for r0/out of range/INIT, else array value
    // overridden by the highest-index matching write this cycle.
    always_comb begin
        rd_data  = '0;
        rd_hit_s = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            if (run_s && gpr_addr_ok(32'(rd_addr[j*ADDR_W +: ADDR_W]), DEPTH)) begin
                rd_data[j*DATA_W +: DATA_W] = mem_r[rd_addr[j*ADDR_W +: ADDR_W]];
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == rd_addr[j*ADDR_W +: ADDR_W])) begin
                        rd_data[j*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
                        rd_hit_s[j] = 1'b1;
                    end else begin
                        rd_hit_s[j] = rd_hit_s[j];
                    end
                end
            end else begin
                rd_data[j*DATA_W +: DATA_W] = '0;
            end
        end
    end

`ifdef GPR_SCOREBOARD_EN
    logic [NUM_RD-1:0] sb_pend_s;

    gpr_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .run         (run_s),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .rd_pend     (sb_pend_s)
    );

    // A write landing this cycle is forwarded, so the reader need not stall.
    assign rd_pending = sb_pend_s & ~rd_hit_s & {NUM_RD{run_s}};
`else
    logic unused_sb_s;
    assign unused_sb_s = ^{sb_set_en, sb_set_addr, rd_hit_s};
    assign rd_pending  = '0;
`endif

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb_gpr_file_mp: self-checking bench for gpr_file_mp (default parameters).
// Expected pending bits are only non-zero when GPR_SCOREBOARD_EN is defined;
// data expectations are identical in both builds.
module tb_gpr_file_mp;

`ifdef GPR_SCOREBOARD_EN
    localparam logic SB_ON = 1'b1;
`else
    localparam logic SB_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [1:0]    wr_en;
    logic [9:0]    wr_addr;
    logic [63:0]   wr_data;
    logic [19:0]   rd_addr;
    logic [127:0]  rd_data;
    logic [3:0]    rd_pending;
    logic          sb_set_en;
    logic [4:0]    sb_set_addr;
    logic          init_busy;

    gpr_file_mp dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pending  (rd_pending),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .init_busy   (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entry: sel 0..3 = rd_data port, 4..7 = rd_pending port, 8 = init_busy
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [1:0]        we;
        logic [4:0]        wa0;
        logic [31:0]       wd0;
        logic [4:0]        wa1;
        logic [31:0]       wd1;
        logic              se;
        logic [4:0]        sa;
        logic [3:0][4:0]   ra;
        logic [3:0][31:0]  ed;
        logic [3:0]        ep;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_of(input int sel);
        if (sel < 4) return rd_data[sel*32 +: 32];
        else if (sel < 8) return {31'd0, rd_pending[sel-4]};
        else return {31'd0, init_busy};
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // One clock: compare queued expectations mid-cycle, then advance.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, act_of(e.sel), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en       = 2'b00;
        wr_addr     = 10'd0;
        wr_data     = 64'd0;
        sb_set_en   = 1'b0;
        sb_set_addr = 5'd0;
        rd_addr     = 20'd0;
    endtask

    // Count INIT cycles after reset release while hammering writes/sets,
    // checking reads stay zero; expect exactly 32 busy cycles.
    task automatic init_wait(input string tag);
        int n;
        n = 0;
        wr_en       = 2'b11;
        wr_addr     = {5'd6, 5'd5};
        wr_data     = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd5;
        rd_addr     = {5'd5, 5'd5, 5'd6, 5'd5};
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (init_busy === 1'b1) begin
                n++;
                check({tag, "_init_rd"}, rd_data[31:0], 32'd0);
                check({tag, "_init_pend"}, {28'd0, rd_pending}, 32'd0);
            end else begin
                wr_en     = 2'b00;
                sb_set_en = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({tag, "_init_len"}, 32'(n), 32'd32);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic se, input logic [4:0] sa,
                                input logic [19:0] ra, input logic [127:0] ed, input logic [3:0] ep);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.se = se; v.sa = sa; v.ra = ra; v.ed = ed; v.ep = ep;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ra/ed listed port3..port0
        vecs[0]  = mk(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd0, 5'd5, 5'd0, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0}, 4'b0000);
        vecs[1]  = mk(2'b01, 5'd0, 32'h0000_1234, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd0, 5'd5, 5'd0, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0}, 4'b0000);
        vecs[2]  = mk(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0,
                      {5'd7, 5'd0, 5'd0, 5'd0}, {32'h22, 32'd0, 32'd0, 32'd0}, 4'b0000);
        vecs[3]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9,
                      {5'd7, 5'd0, 5'd0, 5'd0}, {32'h22, 32'd0, 32'd0, 32'd0}, 4'b0000);
        vecs[4]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd0, 5'd0, 5'd9, 5'd7}, {32'd0, 32'd0, 32'd0, 32'h22}, 4'b0010);
        vecs[5]  = mk(2'b10, 5'd0, 32'd0, 5'd9, 32'hA5, 1'b0, 5'd0,
                      {5'd0, 5'd0, 5'd9, 5'd0}, {32'd0, 32'd0, 32'hA5, 32'd0}, 4'b0000);
        vecs[6]  = mk(2'b01, 5'd9, 32'h5A, 5'd0, 32'd0, 1'b1, 5'd9,
                      {5'd0, 5'd9, 5'd9, 5'd0}, {32'd0, 32'h5A, 32'h5A, 32'd0}, 4'b0000);
        vecs[7]  = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd0, 5'd9, 5'd9, 5'd0}, {32'd0, 32'h5A, 32'h5A, 32'd0}, 4'b0110);
        vecs[8]  = mk(2'b11, 5'd20, 32'hCAFE, 5'd21, 32'hBEEF, 1'b0, 5'd0,
                      {5'd31, 5'd9, 5'd21, 5'd20}, {32'd0, 32'h5A, 32'hBEEF, 32'hCAFE}, 4'b0100);
        vecs[9]  = mk(2'b01, 5'd9, 32'h66, 5'd0, 32'd0, 1'b1, 5'd0,
                      {5'd9, 5'd0, 5'd21, 5'd20}, {32'h66, 32'd0, 32'hBEEF, 32'hCAFE}, 4'b0000);
        vecs[10] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd9, 5'd0, 5'd21, 5'd20}, {32'h66, 32'd0, 32'hBEEF, 32'hCAFE}, 4'b0000);
        vecs[11] = mk(2'b01, 5'd12, 32'h1, 5'd0, 32'd0, 1'b1, 5'd13,
                      {5'd13, 5'd12, 5'd0, 5'd0}, {32'd0, 32'h1, 32'd0, 32'd0}, 4'b0000);
        vecs[12] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd13, 5'd12, 5'd0, 5'd0}, {32'd0, 32'h1, 32'd0, 32'd0}, 4'b1000);
        vecs[13] = mk(2'b10, 5'd0, 32'd0, 5'd13, 32'h2, 1'b0, 5'd0,
                      {5'd0, 5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000);
        vecs[14] = mk(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0,
                      {5'd13, 5'd12, 5'd0, 5'd0}, {32'h2, 32'h1, 32'd0, 32'd0}, 4'b0000);

        // Reset held for 3 cycles
        rst = 1'b0;
        idle_inputs();
        rd_addr = {5'd5, 5'd5, 5'd5, 5'd5};
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            push("rst_busy", 8, 32'd1);
            push("rst_rd0", 0, 32'd0);
            push("rst_pend0", 4, 32'd0);
            cycle();
        end
        rst = 1'b1;
        init_wait("first");

        // Every register reads zero after INIT (INIT-time writes dropped)
        for (int b = 0; b < 8; b++) begin
            for (int p = 0; p < 4; p++) begin
                rd_addr[p*5 +: 5] = 5'(b*4 + p);
                push("post_init_rd", p, 32'd0);
                push("post_init_pend", 4 + p, 32'd0);
            end
            push("post_init_busy", 8, 32'd0);
            cycle();
        end

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            wr_en       = vecs[i].we;
            wr_addr     = {vecs[i].wa1, vecs[i].wa0};
            wr_data     = {vecs[i].wd1, vecs[i].wd0};
            sb_set_en   = vecs[i].se;
            sb_set_addr = vecs[i].sa;
            rd_addr     = vecs[i].ra;
            for (int p = 0; p < 4; p++) begin
                push($sformatf("vec%0d_rd%0d", i, p), p, vecs[i].ed[p]);
                push($sformatf("vec%0d_pend%0d", i, p), 4 + p,
                     {31'd0, vecs[i].ep[p] & SB_ON});
            end
            cycle();
        end
        idle_inputs();

        // Mid-operation reset during INIT at counter 10
        wr_en       = 2'b01;
        wr_addr     = {5'd0, 5'd3};
        wr_data     = {32'd0, 32'h55};
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd4;
        cycle();
        idle_inputs();
        rd_addr = {5'd0, 5'd0, 5'd4, 5'd3};
        push("pre_rst_r3", 0, 32'h55);
        push("pre_rst_pend4", 5, {31'd0, SB_ON});
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            push("mid_init_busy", 8, 32'd1);
            push("mid_init_r3", 0, 32'd0);
            cycle();
        end
        rst = 1'b0;
        push("rst_at_cnt10_busy", 8, 32'd1);
        cycle();
        rst = 1'b1;
        init_wait("restart");
        rd_addr = {5'd0, 5'd0, 5'd4, 5'd3};
        push("post_restart_r3", 0, 32'd0);
        push("post_restart_pend4", 5, 32'd0);
        push("post_restart_busy", 8, 32'd0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
